// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the RV32 pipeline hazard controller: FSM states,
// forwarding select codes and the per-stage latch-control bundle.
package pipe_ctrl_pkg;

    localparam int unsigned STATE_W  = 2;
    localparam int unsigned FWD_W    = 2;
    localparam int unsigned FLUSH_CW = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_BR_FLUSH   = 2'd2,
        ST_MEM_WAIT   = 2'd3
    } pipe_state_e;

    typedef enum logic [FWD_W-1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    // Latch enables and bubble-inserts for every pipeline register.
    typedef struct packed {
        logic pc_ena;
        logic ifid_ena;
        logic idex_ena;
        logic exmem_ena;
        logic memwb_ena;
        logic ifid_flush;
        logic idex_flush;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTL_GO     = 7'b11111_00;
    localparam stage_ctrl_t CTL_FREEZE = 7'b00000_00;

endpackage

// File: rtl/fwd_sel_unit.sv
// EX-operand forwarding comparator for one source register; EX/MEM beats
// MEM/WB and x0 never forwards.
module fwd_sel_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_save_to_reg,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_save_to_reg,
    output logic [FWD_W-1:0]  sel
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_save_to_reg && (mem_rd != '0) && (mem_rd == ex_rs);
    assign wb_hit  = wb_save_to_reg && (wb_rd != '0) && (wb_rd == ex_rs);

    always_comb begin
        sel = FWD_RF;
        if (mem_hit) begin
            sel = FWD_EXMEM;
        end else if (wb_hit) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline controller: latch enables/flushes, load-use stall, branch
// squash, memory-wait freeze and forwarding selects. Perf counters exist only
// when HAZARD_PERF_CNT_EN is defined; otherwise they read as zero.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned BR_PENALTY = 2,
    parameter int unsigned CNT_W      = 32
) (
    input  logic              stg_clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_rd_memory,
    input  logic              ex_branch_taken,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_save_to_reg,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_save_to_reg,
    input  logic              mem_req,
    input  logic              mem_ack,
    output logic              pc_ena,
    output logic              ifid_ena,
    output logic              idex_ena,
    output logic              exmem_ena,
    output logic              memwb_ena,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    pipe_state_e          state_q, state_d;
    pipe_state_e          ret_q, ret_d;
    logic [FLUSH_CW-1:0]  fcnt_q, fcnt_d;
    stage_ctrl_t          ctl;
    logic                 mem_stall;
    logic                 load_use;
    logic [FWD_W-1:0]     fwd_a_raw, fwd_b_raw;

    assign mem_stall = mem_req && !mem_ack;
    assign load_use  = ex_rd_memory && (ex_rd != '0) &&
                       ((id_rs1_used && (id_rs1 == ex_rd)) ||
                        (id_rs2_used && (id_rs2 == ex_rd)));

    always_ff @(posedge stg_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            ret_q   <= ST_RUN;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Priority: memory freeze, then branch squash, then load-use bubble.
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        fcnt_d  = fcnt_q;
        ctl     = CTL_GO;
        if (mem_stall) begin
            ctl     = CTL_FREEZE;
            state_d = ST_MEM_WAIT;
            if (state_q != ST_MEM_WAIT) begin
                ret_d = (state_q == ST_BR_FLUSH) ? ST_BR_FLUSH : ST_RUN;
            end
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (ex_branch_taken) begin
                        ctl.ifid_flush = 1'b1;
                        ctl.idex_flush = 1'b1;
                        if (BR_PENALTY > 1) begin
                            state_d = ST_BR_FLUSH;
                            fcnt_d  = FLUSH_CW'(BR_PENALTY - 1);
                        end
                    end else if (load_use) begin
                        ctl.pc_ena     = 1'b0;
                        ctl.ifid_ena   = 1'b0;
                        ctl.idex_flush = 1'b1;
                        state_d        = ST_LOAD_STALL;
                    end
                end
                ST_LOAD_STALL: state_d = ST_RUN;
                ST_BR_FLUSH: begin
                    ctl.ifid_flush = 1'b1;
                    if (fcnt_q <= FLUSH_CW'(1)) begin
                        state_d = ST_RUN;
                    end else begin
                        fcnt_d = fcnt_q - FLUSH_CW'(1);
                    end
                end
                ST_MEM_WAIT: state_d = ret_q;
                default:     state_d = ST_RUN;
            endcase
        end
    end

    fwd_sel_unit #(.REG_AW(REG_AW)) u_fwd_a (
        .ex_rs           (ex_rs1),
        .mem_rd          (mem_rd),
        .mem_save_to_reg (mem_save_to_reg),
        .wb_rd           (wb_rd),
        .wb_save_to_reg  (wb_save_to_reg),
        .sel             (fwd_a_raw)
    );

    fwd_sel_unit #(.REG_AW(REG_AW)) u_fwd_b (
        .ex_rs           (ex_rs2),
        .mem_rd          (mem_rd),
        .mem_save_to_reg (mem_save_to_reg),
        .wb_rd           (wb_rd),
        .wb_save_to_reg  (wb_save_to_reg),
        .sel             (fwd_b_raw)
    );

    // Reset forces every control output low, independent of the clock.
    assign pc_ena     = !reset && ctl.pc_ena;
    assign ifid_ena   = !reset && ctl.ifid_ena;
    assign idex_ena   = !reset && ctl.idex_ena;
    assign exmem_ena  = !reset && ctl.exmem_ena;
    assign memwb_ena  = !reset && ctl.memwb_ena;
    assign ifid_flush = !reset && ctl.ifid_flush;
    assign idex_flush = !reset && ctl.idex_flush;
    assign fwd_a      = reset ? FWD_RF : fwd_a_raw;
    assign fwd_b      = reset ? FWD_RF : fwd_b_raw;
    assign state_o    = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Saturating event counters.
    always_ff @(posedge stg_clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_ena && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (ifid_flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized plus directed bench for pipe_hazard_ctrl against a cycle-level
// behavioural model of the pipeline-control rules.
module tb_pipe_hazard_ctrl;

    localparam int unsigned AW = 5;
    localparam int unsigned P  = 2;
    localparam int unsigned CW = 32;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          stg_clk = 1'b0;
    logic          reset;
    logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic          id_rs1_used, id_rs2_used, ex_rd_memory, ex_branch_taken;
    logic          mem_save_to_reg, wb_save_to_reg, mem_req, mem_ack;
    logic          pc_ena, ifid_ena, idex_ena, exmem_ena, memwb_ena;
    logic          ifid_flush, idex_flush;
    logic [1:0]    fwd_a, fwd_b, state_o;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 stg_clk = ~stg_clk;

    pipe_hazard_ctrl #(.REG_AW(AW), .BR_PENALTY(P), .CNT_W(CW)) dut (
        .stg_clk(stg_clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_rd_memory(ex_rd_memory), .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .mem_save_to_reg(mem_save_to_reg),
        .wb_rd(wb_rd), .wb_save_to_reg(wb_save_to_reg),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_ena(pc_ena), .ifid_ena(ifid_ena), .idex_ena(idex_ena),
        .exmem_ena(exmem_ena), .memwb_ena(memwb_ena),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .state_o(state_o),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: pending work expressed as remaining flush cycles / flags.
    bit      m_wait;
    bit      m_bubble_done;
    int      m_flush_left;
    longint  m_stall_cnt;
    longint  m_flush_cnt;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [AW-1:0] rs);
        if (mem_save_to_reg && mem_rd != 0 && mem_rd == rs) return 2'b01;
        if (wb_save_to_reg && wb_rd != 0 && wb_rd == rs)    return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [6:0] ctl_vec();
        return {pc_ena, ifid_ena, idex_ena, exmem_ena, memwb_ena, ifid_flush, idex_flush};
    endfunction

    task automatic model_reset();
        m_wait = 0; m_bubble_done = 0; m_flush_left = 0;
        m_stall_cnt = 0; m_flush_cnt = 0;
    endtask

    task automatic drive_idle();
        id_rs1 = '0; id_rs2 = '0; id_rs1_used = 0; id_rs2_used = 0;
        ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_rd_memory = 0; ex_branch_taken = 0;
        mem_rd = '0; mem_save_to_reg = 0; wb_rd = '0; wb_save_to_reg = 0;
        mem_req = 0; mem_ack = 0;
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_ctl"}, 64'(ctl_vec()), 64'd0);
        check_val({tag, "_fwd"}, 64'({fwd_a, fwd_b}), 64'd0);
        check_val({tag, "_state"}, 64'(state_o), 64'd0);
        check_val({tag, "_stallcnt"}, 64'(stall_cnt), 64'd0);
        check_val({tag, "_flushcnt"}, 64'(flush_cnt), 64'd0);
    endtask

    // One cycle: inputs already driven after a negedge; check, clock, advance model.
    task automatic step(input string tag);
        logic [6:0] e;
        bit  stall, lu, nw, nb;
        int  nf;
        logic [1:0] st;
        #1;
        stall = mem_req && !mem_ack;
        lu = ex_rd_memory && ex_rd != 0 &&
             ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
        e = 7'b1111100; nw = m_wait; nb = m_bubble_done; nf = m_flush_left;
        if (m_wait) begin
            if (stall) e = 7'b0; else nw = 0;
        end else if (stall) begin
            e = 7'b0; nw = 1; nb = 0;
        end else if (m_flush_left > 0) begin
            e[1] = 1'b1; nf = m_flush_left - 1;
        end else if (m_bubble_done) begin
            nb = 0;
        end else if (ex_branch_taken) begin
            e[1:0] = 2'b11; nf = P - 1;
        end else if (lu) begin
            e[6] = 1'b0; e[5] = 1'b0; e[0] = 1'b1; nb = 1;
        end
        st = m_wait ? 2'd3 : (m_flush_left > 0) ? 2'd2 : m_bubble_done ? 2'd1 : 2'd0;
        check_val({tag, "_ctl"}, 64'(ctl_vec()), 64'(e));
        check_val({tag, "_fwd"}, 64'({fwd_a, fwd_b}), 64'({fwd_ref(ex_rs1), fwd_ref(ex_rs2)}));
        check_val({tag, "_state"}, 64'(state_o), 64'(st));
        check_val({tag, "_stallcnt"}, 64'(stall_cnt), 64'(m_stall_cnt));
        check_val({tag, "_flushcnt"}, 64'(flush_cnt), 64'(m_flush_cnt));
        @(posedge stg_clk);
        if (PERF) begin
            if (!e[6]) m_stall_cnt++;
            if (e[1])  m_flush_cnt++;
        end
        m_wait = nw; m_bubble_done = nb; m_flush_left = nf;
        @(negedge stg_clk);
    endtask

    initial begin
        drive_idle();
        reset = 1'b1;
        mem_rd = 5'd7; mem_save_to_reg = 1; ex_rs1 = 5'd7; ex_branch_taken = 1;
        model_reset();
        #3 check_reset("por");
        @(negedge stg_clk);
        reset = 1'b0;
        drive_idle();

        // Load-use: one bubble, then LOAD_STALL with detection suppressed.
        ex_rd_memory = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1;
        step("lu_detect");
        step("lu_stall");
        drive_idle();
        step("lu_run");
        check_val("lu_stallcnt_abs", 64'(stall_cnt), PERF ? 64'd1 : 64'd0);

        // Taken branch with two-cycle penalty.
        ex_branch_taken = 1;
        step("br_take");
        ex_branch_taken = 1;
        step("br_flush_ignore");
        ex_branch_taken = 0;
        step("br_run");
        check_val("br_flushcnt_abs", 64'(flush_cnt), PERF ? 64'd2 : 64'd0);

        // Memory wait: three frozen cycles then ack.
        mem_req = 1; mem_ack = 0;
        repeat (3) step("mw_freeze");
        mem_ack = 1;
        step("mw_ack");
        check_val("mw_state_abs", 64'(state_o), 64'd0);
        drive_idle();
        step("mw_after");

        // Forwarding priority and x0.
        mem_rd = 5'd7; wb_rd = 5'd7; mem_save_to_reg = 1; wb_save_to_reg = 1;
        ex_rs1 = 5'd7; ex_rs2 = 5'd0;
        step("fwd_both");
        mem_save_to_reg = 0;
        #1 check_val("fwd_wb_abs", 64'(fwd_a), 64'd2);
        step("fwd_wb");
        drive_idle();

        // Branch beats load-use; memory stall freezes the flush countdown.
        ex_branch_taken = 1; ex_rd_memory = 1; ex_rd = 5'd3; id_rs2 = 5'd3; id_rs2_used = 1;
        #1 check_val("prio_ctl_abs", 64'(ctl_vec()), 64'h7f);
        step("prio_br_lu");
        drive_idle();
        mem_req = 1;
        step("prio_stall_in_flush");
        step("prio_wait");
        mem_ack = 1;
        step("prio_ack");
        drive_idle();
        step("prio_flush_resume");
        step("prio_run");

        // Asynchronous reset while in MEM_WAIT.
        mem_req = 1;
        step("rst_wait0");
        step("rst_wait1");
        #2 reset = 1'b1;
        #1 check_reset("rst_async");
        model_reset();
        @(negedge stg_clk);
        reset = 1'b0;
        drive_idle();
        step("rst_after0");
        ex_branch_taken = 1;
        step("rst_after_br");
        ex_branch_taken = 0;
        step("rst_after_flush");

        // Randomized traffic over a small register space to provoke matches.
        for (int i = 0; i < 600; i++) begin
            id_rs1 = AW'($urandom_range(0, 3)); id_rs2 = AW'($urandom_range(0, 3));
            id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom);
            ex_rs1 = AW'($urandom_range(0, 3)); ex_rs2 = AW'($urandom_range(0, 3));
            ex_rd = AW'($urandom_range(0, 3));
            ex_rd_memory = ($urandom_range(0, 9) < 4);
            ex_branch_taken = ($urandom_range(0, 99) < 15);
            mem_rd = AW'($urandom_range(0, 3)); mem_save_to_reg = 1'($urandom);
            wb_rd = AW'($urandom_range(0, 3));  wb_save_to_reg = 1'($urandom);
            mem_req = ($urandom_range(0, 99) < 25);
            mem_ack = 1'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1'b1;
                #1 check_reset("rnd_rst");
                model_reset();
                @(negedge stg_clk);
                reset = 1'b0;
            end else begin
                step("rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
